// File: rtl/pc_redirect_unit.sv
// Fetch PC register with branch/jump redirect, a fixed-length flush window,
// a saturating redirect counter and a sticky misaligned-target flag.
module pc_redirect_unit #(
    parameter logic [63:0] RESET_PC     = 64'h0,
    parameter int unsigned FLUSH_CYCLES = 2
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        pc_write_en,
    input  logic        br_valid,
    input  logic [1:0]  br_kind,
    input  logic        br_taken,
    input  logic [63:0] pc_ex,
    input  logic [63:0] imm,
    input  logic [63:0] rs1,
    output logic [63:0] pc,
    output logic [63:0] pc_plus4,
    output logic        flush,
    output logic [15:0] redirect_cnt,
    output logic        misalign_err
);

    typedef enum logic [1:0] {StRun, StF1, StF2, StF3} state_e;

    state_e      state_q, state_d;
    logic [63:0] pc_q, pc_d;
    logic        flush_q, flush_d;
    logic [15:0] cnt_q, cnt_d;
    logic        mis_q, mis_d;

    logic [63:0] sum_pc, sum_rs1, target;
    logic        is_cf, req, aligned, accept;

    always_comb begin
        sum_pc  = pc_ex + imm;
        sum_rs1 = rs1 + imm;
        target  = (br_kind == 2'b11) ? {sum_rs1[63:1], 1'b0} : sum_pc;

        case (br_kind)
            2'b01:   is_cf = br_taken;
            2'b10:   is_cf = 1'b1;
            2'b11:   is_cf = 1'b1;
            default: is_cf = 1'b0;
        endcase

        // Resolutions arriving inside the flush window belong to squashed work.
        req     = br_valid && (state_q == StRun) && is_cf;
        aligned = (target[1:0] == 2'b00);
        accept  = req && aligned;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            StRun:   if (accept) state_d = StF1;
            StF1:    state_d = (FLUSH_CYCLES > 1) ? StF2 : StRun;
            StF2:    state_d = (FLUSH_CYCLES > 2) ? StF3 : StRun;
            StF3:    state_d = StRun;
            default: state_d = StRun;
        endcase

        flush_d = (state_d != StRun);

        // Redirect wins over stall.
        if (accept) begin
            pc_d = target;
        end else if (pc_write_en) begin
            pc_d = pc_q + 64'd4;
        end else begin
            pc_d = pc_q;
        end

        cnt_d = (accept && (cnt_q != 16'hFFFF)) ? cnt_q + 16'd1 : cnt_q;
        mis_d = mis_q | (req & ~aligned);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= StRun;
            pc_q    <= RESET_PC;
            flush_q <= 1'b0;
            cnt_q   <= 16'd0;
            mis_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            flush_q <= flush_d;
            cnt_q   <= cnt_d;
            mis_q   <= mis_d;
        end
    end

    assign pc           = pc_q;
    assign pc_plus4     = pc_q + 64'd4;
    assign flush        = flush_q;
    assign redirect_cnt = cnt_q;
    assign misalign_err = mis_q;

endmodule

// File: tb/tb_pc_redirect_unit.sv
// Self-checking bench for pc_redirect_unit: vector table through a scoreboard,
// then reset-mid-flush and counter saturation sequences.
module tb_pc_redirect_unit;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset_n;
    logic        pc_write_en, br_valid, br_taken;
    logic [1:0]  br_kind;
    logic [63:0] pc_ex, imm, rs1;
    logic [63:0] pc, pc_plus4;
    logic        flush, misalign_err;
    logic [15:0] redirect_cnt;

    logic        we2, valid2, taken2;
    logic [1:0]  kind2;
    logic [63:0] pc_ex2, imm2, rs1_2;
    logic [63:0] pc2, pc_plus4_2;
    logic        flush2, mis2;
    logic [15:0] cnt2;

    pc_redirect_unit #(.RESET_PC(64'h0), .FLUSH_CYCLES(2)) dut (
        .clk(clk), .reset_n(reset_n), .pc_write_en(pc_write_en), .br_valid(br_valid),
        .br_kind(br_kind), .br_taken(br_taken), .pc_ex(pc_ex), .imm(imm), .rs1(rs1),
        .pc(pc), .pc_plus4(pc_plus4), .flush(flush), .redirect_cnt(redirect_cnt),
        .misalign_err(misalign_err)
    );

    pc_redirect_unit #(.RESET_PC(64'h1000), .FLUSH_CYCLES(1)) dut_f1 (
        .clk(clk), .reset_n(reset_n), .pc_write_en(we2), .br_valid(valid2),
        .br_kind(kind2), .br_taken(taken2), .pc_ex(pc_ex2), .imm(imm2), .rs1(rs1_2),
        .pc(pc2), .pc_plus4(pc_plus4_2), .flush(flush2), .redirect_cnt(cnt2),
        .misalign_err(mis2)
    );

    typedef struct {
        logic        we;
        logic        valid;
        logic [1:0]  kind;
        logic        taken;
        logic [63:0] pc_ex;
        logic [63:0] imm;
        logic [63:0] rs1;
        logic [63:0] exp_pc;
        logic        exp_flush;
        logic [15:0] exp_cnt;
        logic        exp_mis;
    } vec_t;

    typedef struct {
        logic [63:0] pc;
        logic        flush;
        logic [15:0] cnt;
        logic        mis;
    } exp_t;

    vec_t vecs[$];
    exp_t sb_q[$];
    int   n_checks = 0;
    int   n_pass   = 0;

    function automatic vec_t mk(input logic we, input logic valid, input logic [1:0] kind,
                                input logic taken, input logic [63:0] a_pc_ex,
                                input logic [63:0] a_imm, input logic [63:0] a_rs1,
                                input logic [63:0] e_pc, input logic e_flush,
                                input logic [15:0] e_cnt, input logic e_mis);
        vec_t v;
        v.we = we; v.valid = valid; v.kind = kind; v.taken = taken;
        v.pc_ex = a_pc_ex; v.imm = a_imm; v.rs1 = a_rs1;
        v.exp_pc = e_pc; v.exp_flush = e_flush; v.exp_cnt = e_cnt; v.exp_mis = e_mis;
        return v;
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    endtask

    task automatic apply(input vec_t v, input string tag);
        exp_t e, got;
        @(negedge clk);
        pc_write_en = v.we; br_valid = v.valid; br_kind = v.kind; br_taken = v.taken;
        pc_ex = v.pc_ex; imm = v.imm; rs1 = v.rs1;
        e.pc = v.exp_pc; e.flush = v.exp_flush; e.cnt = v.exp_cnt; e.mis = v.exp_mis;
        sb_q.push_back(e);
        @(posedge clk);
        #1;
        got = sb_q.pop_front();
        chk({tag, " pc"}, pc, got.pc);
        chk({tag, " pc_plus4"}, pc_plus4, got.pc + 64'd4);
        chk({tag, " flush"}, {63'd0, flush}, {63'd0, got.flush});
        chk({tag, " redirect_cnt"}, {48'd0, redirect_cnt}, {48'd0, got.cnt});
        chk({tag, " misalign_err"}, {63'd0, misalign_err}, {63'd0, got.mis});
    endtask

    task automatic idle_inputs();
        pc_write_en = 1'b0; br_valid = 1'b0; br_kind = 2'b00; br_taken = 1'b0;
        pc_ex = '0; imm = '0; rs1 = '0;
    endtask

    initial begin
        reset_n = 1'b0;
        idle_inputs();
        we2 = 1'b0; valid2 = 1'b0; kind2 = 2'b00; taken2 = 1'b0;
        pc_ex2 = '0; imm2 = '0; rs1_2 = '0;

        #12;
        chk("reset pc", pc, 64'h0);
        chk("reset flush", {63'd0, flush}, 64'd0);
        chk("reset cnt", {48'd0, redirect_cnt}, 64'd0);
        chk("reset misalign", {63'd0, misalign_err}, 64'd0);
        chk("reset pc2", pc2, 64'h1000);
        #10 reset_n = 1'b1;
        #2;
        chk("post-release pc", pc, 64'h0);
        chk("post-release flush", {63'd0, flush}, 64'd0);

        vecs.push_back(mk(1, 0, 2'b00, 0, 64'h0, 64'h0, 64'h0, 64'h4, 0, 16'd0, 0));
        vecs.push_back(mk(1, 0, 2'b00, 0, 64'h0, 64'h0, 64'h0, 64'h8, 0, 16'd0, 0));
        vecs.push_back(mk(1, 0, 2'b00, 0, 64'h0, 64'h0, 64'h0, 64'hC, 0, 16'd0, 0));
        vecs.push_back(mk(0, 0, 2'b00, 0, 64'h0, 64'h0, 64'h0, 64'hC, 0, 16'd0, 0));
        vecs.push_back(mk(0, 0, 2'b00, 0, 64'h0, 64'h0, 64'h0, 64'hC, 0, 16'd0, 0));
        vecs.push_back(mk(1, 0, 2'b00, 0, 64'h0, 64'h0, 64'h0, 64'h10, 0, 16'd0, 0));
        // taken branch under stall, then the two flush cycles
        vecs.push_back(mk(0, 1, 2'b01, 1, 64'h100, 64'h40, 64'h0, 64'h140, 1, 16'd1, 0));
        vecs.push_back(mk(0, 0, 2'b00, 0, 64'h0, 64'h0, 64'h0, 64'h140, 1, 16'd1, 0));
        vecs.push_back(mk(0, 0, 2'b00, 0, 64'h0, 64'h0, 64'h0, 64'h140, 0, 16'd1, 0));
        // JALR with bit 0 cleared, JAL during F1 ignored
        vecs.push_back(mk(1, 1, 2'b11, 0, 64'h0, 64'h10, 64'h2001, 64'h2010, 1, 16'd2, 0));
        vecs.push_back(mk(1, 1, 2'b10, 0, 64'h100, 64'h40, 64'h0, 64'h2014, 1, 16'd2, 0));
        vecs.push_back(mk(1, 0, 2'b00, 0, 64'h0, 64'h0, 64'h0, 64'h2018, 0, 16'd2, 0));
        // misaligned JAL, not-taken, kind 00, valid low
        vecs.push_back(mk(1, 1, 2'b10, 0, 64'h100, 64'h6, 64'h0, 64'h201C, 0, 16'd2, 1));
        vecs.push_back(mk(1, 1, 2'b01, 0, 64'h100, 64'h40, 64'h0, 64'h2020, 0, 16'd2, 1));
        vecs.push_back(mk(1, 1, 2'b00, 1, 64'h100, 64'h40, 64'h0, 64'h2024, 0, 16'd2, 1));
        vecs.push_back(mk(1, 0, 2'b10, 0, 64'h100, 64'h40, 64'h0, 64'h2028, 0, 16'd2, 1));
        vecs.push_back(mk(0, 1, 2'b11, 0, 64'h0, 64'h2, 64'h2001, 64'h2028, 0, 16'd2, 1));
        // wraparound of the JALR sum and of pc+4
        vecs.push_back(mk(0, 1, 2'b11, 0, 64'h0, 64'hC, 64'hFFFF_FFFF_FFFF_FFF0,
                          64'hFFFF_FFFF_FFFF_FFFC, 1, 16'd3, 1));
        vecs.push_back(mk(1, 0, 2'b00, 0, 64'h0, 64'h0, 64'h0, 64'h0, 1, 16'd3, 1));
        vecs.push_back(mk(1, 0, 2'b00, 0, 64'h0, 64'h0, 64'h0, 64'h4, 0, 16'd3, 1));
        vecs.push_back(mk(1, 1, 2'b10, 0, 64'hFFFF_FFFF_FFFF_FF00, 64'h200, 64'h0,
                          64'h100, 1, 16'd4, 1));
        vecs.push_back(mk(1, 0, 2'b00, 0, 64'h0, 64'h0, 64'h0, 64'h104, 1, 16'd4, 1));
        vecs.push_back(mk(1, 0, 2'b00, 0, 64'h0, 64'h0, 64'h0, 64'h108, 0, 16'd4, 1));

        foreach (vecs[i]) apply(vecs[i], $sformatf("row%0d", i));

        // misalign_err stays set across idle cycles
        for (int k = 0; k < 10; k++) begin
            apply(mk(0, 0, 2'b00, 0, 64'h0, 64'h0, 64'h0, 64'h108, 0, 16'd4, 1),
                  $sformatf("sticky%0d", k));
        end

        // reset asserted mid-cycle during F1
        apply(mk(0, 1, 2'b10, 0, 64'h300, 64'h20, 64'h0, 64'h320, 1, 16'd5, 1), "pre-reset");
        idle_inputs();
        #2 reset_n = 1'b0;
        #1;
        chk("midflush pc", pc, 64'h0);
        chk("midflush flush", {63'd0, flush}, 64'd0);
        chk("midflush cnt", {48'd0, redirect_cnt}, 64'd0);
        chk("midflush misalign", {63'd0, misalign_err}, 64'd0);
        @(negedge clk);
        #2 reset_n = 1'b1;
        br_valid = 1'b1; br_kind = 2'b10; pc_ex = 64'h0; imm = 64'h80;
        #1;
        chk("release hold pc", pc, 64'h0);
        chk("release hold flush", {63'd0, flush}, 64'd0);
        @(posedge clk);
        #1;
        chk("first edge pc", pc, 64'h80);
        chk("first edge flush", {63'd0, flush}, 64'd1);
        chk("first edge cnt", {48'd0, redirect_cnt}, 64'd1);
        idle_inputs();

        // FLUSH_CYCLES=1 instance: one-cycle flush, then drive to saturation
        @(negedge clk);
        we2 = 1'b0; valid2 = 1'b1; kind2 = 2'b10; pc_ex2 = 64'h0; imm2 = 64'h100;
        @(posedge clk);
        #1;
        chk("f1 pc", pc2, 64'h100);
        chk("f1 flush", {63'd0, flush2}, 64'd1);
        chk("f1 cnt", {48'd0, cnt2}, 64'd1);
        @(posedge clk);
        #1;
        chk("f1 flush end", {63'd0, flush2}, 64'd0);
        repeat (2 * 65539) @(posedge clk);
        #1;
        chk("sat cnt", {48'd0, cnt2}, 64'hFFFF);
        chk("sat pc", pc2, 64'h100);
        chk("sat flush", {63'd0, flush2}, 64'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/pc_redirect_unit.md
PC_REDIRECT_UNIT -- requirements
Module: pc_redirect_unit

Interface
REQ-001 Parameters SHALL be, one per line:
  RESET_PC  64'h0  PC value loaded on reset
  FLUSH_CYCLES  2  number of cycles flush is held after a redirect (legal range 1..3)
REQ-002 Ports SHALL be, one per line:
  clk  in  1  sole clock, rising edge
  reset_n  in  1  asynchronous, active-low reset
  pc_write_en  in  1  1 = advance PC; 0 = stall
  br_valid  in  1  control-flow instruction resolved this cycle
  br_kind  in  2  00 none, 01 conditional branch, 10 JAL, 11 JALR
  br_taken  in  1  branch condition from the condition-select mux
  pc_ex  in  64  PC of the resolving instruction
  imm  in  64  sign-extended immediate
  rs1  in  64  rs1 operand, used for JALR only
  pc  out  64  current fetch PC
  pc_plus4  out  64  pc + 4, combinational
  flush  out  1  squash younger instructions
  redirect_cnt  out  16  saturating count of accepted redirects
  misalign_err  out  1  sticky flag for a misaligned target
REQ-003 Only one clock domain SHALL exist; reset SHALL be asynchronous and active-low, with deassertion sampled on clk.

Function
REQ-004 Target calculation SHALL be:
  br_kind 01 or 10: target = pc_ex + imm.
  br_kind 11: target = (rs1 + imm) with bit 0 cleared.
  All sums are 64-bit and wrap modulo 2^64 with no overflow flag.
REQ-005 A redirect request SHALL exist when br_valid=1 and the state is RUN and one of these holds:
  br_kind=10
  br_kind=11
  br_kind=01 with br_taken=1
REQ-006 br_kind=00, or br_kind=01 with br_taken=0, SHALL NOT redirect and SHALL NOT change the FSM state.
REQ-007 A redirect request whose target[1:0] != 00 SHALL NOT redirect. It SHALL set misalign_err to 1 on the next edge, and the PC SHALL follow the normal sequential/stall rule.
REQ-008 An accepted redirect SHALL load pc <= target on the next edge even if pc_write_en=0 (redirect has priority over stall).
REQ-009 With no accepted redirect, pc SHALL load pc+4 when pc_write_en=1 and hold otherwise. +4 wraps modulo 2^64.
REQ-010 The FSM SHALL have these states and transitions:
  RUN, F1, F2, F3.
  RUN goes to F1 on an accepted redirect.
  Fk goes to F(k+1) while k < FLUSH_CYCLES.
  F(FLUSH_CYCLES) goes to RUN.
REQ-011 flush SHALL be a registered output, equal to 1 exactly while the state is F1..F(FLUSH_CYCLES), i.e. for FLUSH_CYCLES cycles starting the cycle after the accepting edge.
REQ-012 While the state is not RUN, br_valid SHALL be ignored: no redirect, no misalign_err update, no count. The PC SHALL still obey REQ-009.
REQ-013 Flush states SHALL advance every cycle regardless of pc_write_en.
REQ-014 redirect_cnt SHALL increment by 1 per accepted redirect and saturate at 16'hFFFF.
REQ-015 misalign_err SHALL stay 1 once set, until reset.
REQ-016 pc_plus4 SHALL always equal pc + 4 with zero-cycle latency.

Reset
REQ-017 While reset_n=0, asynchronously and independent of clk, the block SHALL force:
  pc = RESET_PC
  state = RUN
  flush = 0
  redirect_cnt = 0
  misalign_err = 0
REQ-018 Reset asserted during a flush sequence SHALL abort it. After release, the first edge SHALL behave as the RUN state.
REQ-019 No output other than pc_plus4 SHALL change between the release of reset_n and the first rising edge of clk.

Verification
REQ-020 Sequential and stall: reset, then pc_write_en=1 for 3 cycles, 0 for 2, 1 for 1. Required: pc = 0, 4, 8, 12, 12, 12, 16; flush stays 0.
REQ-021 Taken branch with stall: pc_ex=0x100, imm=0x40, br_kind=01, br_taken=1, pc_write_en=0. Required: pc=0x140 after the edge; flush=1 for exactly 2 cycles; redirect_cnt=1.
REQ-022 JALR bit-clear, then blocked redirect: rs1=0x2001, imm=0x10, br_kind=11. Required: pc=0x2010. A JAL presented during F1 SHALL be ignored and redirect_cnt SHALL stay 1.
REQ-023 Misaligned target: br_kind=10, pc_ex=0x100, imm=0x6. Required: no redirect, pc=old pc+4, misalign_err=1 and still 1 after 10 more cycles, flush=0.
REQ-024 Not-taken and saturation: br_kind=01 with br_taken=0 SHALL give pc+4 only. Force 65540 accepted redirects; redirect_cnt SHALL read 16'hFFFF.
REQ-025 Reset mid-flush: assert reset_n=0 mid-cycle during F1. Required: pc=RESET_PC, flush=0 and redirect_cnt=0 immediately, before any clock edge.
